// File: rtl/ic_req_upload.sv
// Instruction-cache request upload serializer: one 48-bit request message is
// buffered and drained as head/body/tail 16-bit flits toward the request FIFO.
module ic_req_upload (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] ic_flits_req,
  input  logic        v_ic_flits_req,
  input  logic        req_fifo_rdy,
  output logic [15:0] ic_flit_out,
  output logic        v_ic_flit_out,
  output logic [1:0]  ic_ctrl_out,
  output logic        ic_req_upload_state
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [47:0] msg_q, msg_d;

  // Handshake: a flit moves on any rising edge where v_ic_flit_out=1
  // (BUSY and req_fifo_rdy); otherwise the same flit is held stable.
  // Messages are captured only in IDLE, independent of req_fifo_rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      msg_q   <= 48'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    case (state_q)
      IDLE: begin
        if (v_ic_flits_req) begin
          msg_d   = ic_flits_req;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (req_fifo_rdy) begin
          // cnt=3 cannot occur, but is retired as a tail if it ever does
          if (cnt_q >= 2'd2) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            msg_d   = 48'h0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ic_flit_out         = 16'h0000;
    ic_ctrl_out         = CTRL_HEAD;
    v_ic_flit_out       = 1'b0;
    ic_req_upload_state = state_q;
    if (state_q == BUSY) begin
      v_ic_flit_out = req_fifo_rdy;
      case (cnt_q)
        2'd0: begin
          ic_flit_out = msg_q[47:32];
          ic_ctrl_out = CTRL_HEAD;
        end
        2'd1: begin
          ic_flit_out = msg_q[31:16];
          ic_ctrl_out = CTRL_BODY;
        end
        default: begin
          ic_flit_out = msg_q[15:0];
          ic_ctrl_out = CTRL_TAIL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ic_req_upload.sv
// Directed bench for ic_req_upload: reset, drain, back-pressure, busy-ignore
// and asynchronous reset, with hand-computed flit/valid/ctrl/state vectors.
module tb_ic_req_upload;

  logic        clk;
  logic        rst;
  logic [47:0] ic_flits_req;
  logic        v_ic_flits_req;
  logic        req_fifo_rdy;
  logic [15:0] ic_flit_out;
  logic        v_ic_flit_out;
  logic [1:0]  ic_ctrl_out;
  logic        ic_req_upload_state;

  int checks = 0;
  int errors = 0;

  ic_req_upload dut (
    .clk                 (clk),
    .rst                 (rst),
    .ic_flits_req        (ic_flits_req),
    .v_ic_flits_req      (v_ic_flits_req),
    .req_fifo_rdy        (req_fifo_rdy),
    .ic_flit_out         (ic_flit_out),
    .v_ic_flit_out       (v_ic_flit_out),
    .ic_ctrl_out         (ic_ctrl_out),
    .ic_req_upload_state (ic_req_upload_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packed as {flit, valid, ctrl, state}
  task automatic chk(input string tag, input logic [15:0] flit, input logic v,
                     input logic [1:0] ctrl, input logic st);
    logic [19:0] obs;
    logic [19:0] exp_v;
    obs   = {ic_flit_out, v_ic_flit_out, ic_ctrl_out, ic_req_upload_state};
    exp_v = {flit, v, ctrl, st};
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed flit=%h v=%b ctrl=%b st=%b expected flit=%h v=%b ctrl=%b st=%b",
             tag, obs[19:4], obs[3], obs[2:1], obs[0], flit, v, ctrl, st);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    ic_flits_req   = 48'h0;
    v_ic_flits_req = 1'b0;
    req_fifo_rdy   = 1'b1;
    #1;
    chk("reset_async", 16'h0000, 1'b0, 2'b01, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    chk("reset_release", 16'h0000, 1'b0, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle", 16'h0000, 1'b0, 2'b01, 1'b0);
    end

    // back-to-back drain
    ic_flits_req   = 48'h12345678abcd;
    v_ic_flits_req = 1'b1;
    tick();
    v_ic_flits_req = 1'b0;
    ic_flits_req   = 48'h0;
    chk("b2b_head", 16'h1234, 1'b1, 2'b01, 1'b1);
    tick();
    chk("b2b_body", 16'h5678, 1'b1, 2'b10, 1'b1);
    tick();
    chk("b2b_tail", 16'habcd, 1'b1, 2'b11, 1'b1);
    tick();
    chk("b2b_idle", 16'h0000, 1'b0, 2'b01, 1'b0);

    // capture under back-pressure
    ic_flits_req   = 48'hc0de2016c0de;
    v_ic_flits_req = 1'b1;
    req_fifo_rdy   = 1'b0;
    tick();
    v_ic_flits_req = 1'b0;
    chk("bp_capture", 16'hc0de, 1'b0, 2'b01, 1'b1);
    tick();
    chk("bp_head_hold", 16'hc0de, 1'b0, 2'b01, 1'b1);
    req_fifo_rdy = 1'b1;
    #1;
    chk("bp_head_rdy", 16'hc0de, 1'b1, 2'b01, 1'b1);
    tick();
    chk("bp_body", 16'h2016, 1'b1, 2'b10, 1'b1);

    // body stall while a different message is offered and must be ignored
    req_fifo_rdy   = 1'b0;
    ic_flits_req   = 48'hffffeeeeddd1;
    v_ic_flits_req = 1'b1;
    #1;
    chk("stall_body_v0", 16'h2016, 1'b0, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_body_hold", 16'h2016, 1'b0, 2'b10, 1'b1);
    end
    req_fifo_rdy = 1'b1;
    #1;
    chk("stall_body_rdy", 16'h2016, 1'b1, 2'b10, 1'b1);
    tick();
    chk("stall_tail", 16'hc0de, 1'b1, 2'b11, 1'b1);
    // v_ic_flits_req still high across the tail edge: no same-edge capture
    tick();
    chk("tail_no_capture", 16'h0000, 1'b0, 2'b01, 1'b0);

    // first edge back in IDLE captures the next message
    ic_flits_req = 48'ha1a2b3b4c5c6;
    tick();
    v_ic_flits_req = 1'b0;
    chk("recapture_head", 16'ha1a2, 1'b1, 2'b01, 1'b1);
    tick();
    chk("recapture_body", 16'hb3b4, 1'b1, 2'b10, 1'b1);

    // asynchronous reset while the body flit is presented
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_mid", 16'h0000, 1'b0, 2'b01, 1'b0);
    tick();
    chk("async_rst_hold", 16'h0000, 1'b0, 2'b01, 1'b0);
    rst = 1'b1;
    tick();
    chk("post_rst_discard", 16'h0000, 1'b0, 2'b01, 1'b0);
    tick();
    chk("post_rst_idle", 16'h0000, 1'b0, 2'b01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
